uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Runtime-configurable UART receiver; successor to the fixed 8N1 receiver.
//  - Per-frame data width 5..DBIT_MAX, parity none/even/odd, 1 or 2 stop bits.
//  - Reports parity error, framing error and break; rejects false starts.
//  - Sits between the baud-tick generator (s_tick) and the rx FIFO/bus interface.
// PARAMETERS
//  DBIT_MAX     8   max data bits; dout width
//  OVS          16  s_tick oversampling ticks per bit; even, >=8
//  SYNC_STAGES  2   rx synchroniser flops; >=2
// PORTS
//  clk          in   1         clock
//  reset        in   1         asynchronous, active-high reset
//  rx           in   1         serial line, async, idle high
//  s_tick       in   1         oversample enable, 1 clk wide, OVS per bit
//  data_bits    in   2         00=5,01=6,10=7,11=8 (clamped to DBIT_MAX)
//  parity_mode  in   2         00 none, 01 even, 10 odd, 11 = none
//  stop_bits    in   1         0 = one, 1 = two
//  rx_done_tick out  1         1-clk pulse: frame complete, dout/flags valid
//  dout         out  DBIT_MAX  received data, LSB-first, right-justified, upper bits 0
//  parity_err   out  1         parity mismatch in last frame
//  frame_err    out  1         any stop bit sampled 0 in last frame
//  break_det    out  1         last frame all-zero incl. parity and stop
// BEHAVIOUR
//  - Reset: state IDLE, all counters 0, every output 0.
//  - rx passes SYNC_STAGES flops; all logic uses synchronised rxs (+SYNC_STAGES clk latency).
//  - FSM IDLE->START->DATA->[PARITY]->STOP->IDLE; s/n counters advance only on s_tick.
//  - IDLE: falling edge of rxs (prev 1, now 0) -> START, s=0.
//    - data_bits, parity_mode and stop_bits latched here.
//    - Config changes mid-frame are ignored.
//    - rx held low after a frame gives no new start until rxs returns high.
//  - START: at s==OVS/2-1 sample.
//    - 1 -> false start: IDLE, no pulse, outputs unchanged.
//    - 0 -> DATA, s=0, n=0.
//  - DATA: at s==OVS-1 sample bit into shift reg, s=0.
//    - After nbits bits -> PARITY if enabled, else STOP.
//  - PARITY: at s==OVS-1 sample p, s=0.
//    - even: err = ^data ^ p; odd: err = ~(^data ^ p).
//    - Then -> STOP.
//  - STOP: at s==OVS-1 sample stop bit; any 0 sets frame_err.
//    - After the 1st or 2nd (per stop_bits) stop bit -> IDLE.
//    - Same edge: registered dout, parity_err, frame_err, break_det updated.
//    - rx_done_tick high exactly the next clk cycle.
//  - Outputs hold until the next rx_done_tick; a false start never alters them.
//  - parity_err is always 0 when parity is none.
//  - break_det = data==0 & (no parity | p==0) & all stop bits 0; implies frame_err.
//  - s_tick absent: state and counters frozen. Reset mid-frame: immediate IDLE, outputs 0.
// CONFIGURATION
//  - UART_RX_MAJORITY_EN defined: each bit value (start, data, parity, stop) is a
//    2-of-3 majority of samples at ticks K-2, K-1, K (K = OVS/2-1 for start, else OVS-1).
//  - Undefined: single sample at tick K. Timing, pulse position and latency are identical either way.
// STRUCTURE
//  - uart_pkg: state_t enum {IDLE,START,DATA,PARITY,STOP}; parity_t enum {PAR_NONE,PAR_EVEN,PAR_ODD};
//    nbits decode function.
//  - Sub-module uart_rx_sampler: synchroniser, edge detect, majority vote (macro-gated).
//  - Parent: FSM, counters, shift reg, output regs.
// TESTING
//  - 8N1 (data_bits=11, parity 00, stop 0), send 0xA5 -> one done pulse, dout=0xA5, all flags 0.
//  - 7E1, send 0x35 with parity bit 0 -> dout=0x35, parity_err=0; repeat with parity bit 1
//    -> parity_err=1.
//  - 5O2, send 0x1F, 2nd stop bit 0 -> dout=0x1F, frame_err=1, break_det=0.
//  - 8N1, rx low for 12 bit times then high -> done with dout=0, frame_err=1, break_det=1;
//    no second frame until rx returns high.
//  - rx low pulse of OVS/4 ticks -> no done pulse, outputs unchanged; next valid 0x3C received correctly.
//  - Assert reset mid-DATA -> all outputs 0, IDLE; next 0x81 received correctly.
//  - With UART_RX_MAJORITY_EN: 1-tick glitch at a data sample point -> dout correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and decode helpers for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  // 00..11 selects 5..8 data bits; a narrower build clamps to its maximum.
  function automatic logic [3:0] nbits_decode(input logic [1:0] code,
                                              input int unsigned dbit_max);
    int unsigned n;
    n = 32'(code) + 32'd5;
    if (n > dbit_max) n = dbit_max;
    return n[3:0];
  endfunction

  // Code 11 is treated as no parity.
  function automatic parity_t parity_decode(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: rx synchroniser, falling-edge detect and bit-value sampling.
// With UART_RX_MAJORITY_EN the bit value is a 2-of-3 vote over the last three s_tick samples.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic s_tick,
  output logic fall,
  output logic bit_val
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rxs;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    prev_d = rxs;
  end

  // Idle-high reset values keep reset release from looking like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign fall = prev_q & ~rxs;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] holds the sample from the previous tick, hist_q[1] the one before.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (s_tick) hist_d = {hist_q[0], rxs};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= hist_d;
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  logic unused_tick;
  assign unused_tick = s_tick;
  assign bit_val     = rxs;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5..DBIT_MAX data bits, none/even/odd parity, 1/2 stop).
// Optional UART_RX_MAJORITY_EN selects majority-vote sampling inside uart_rx_sampler.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT_MAX    = 8,
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  input  logic                s_tick,
  input  logic [1:0]          data_bits,
  input  logic [1:0]          parity_mode,
  input  logic                stop_bits,
  output logic                rx_done_tick,
  output logic [DBIT_MAX-1:0] dout,
  output logic                parity_err,
  output logic                frame_err,
  output logic                break_det,
  output logic [2:0]          dbg_state
);

  localparam int             SW    = $clog2(OVS);
  localparam logic [SW-1:0]  S_MID = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0]  S_END = SW'(OVS - 1);

  logic fall, bit_val;

  uart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .s_tick  (s_tick),
    .fall    (fall),
    .bit_val (bit_val)
  );

  state_t              state_q, state_d;
  logic [SW-1:0]       s_q, s_d;
  logic [3:0]          n_q, n_d;
  logic [3:0]          nbits_q, nbits_d;
  parity_t             par_q, par_d;
  logic                two_stop_q, two_stop_d;
  logic [DBIT_MAX-1:0] shreg_q, shreg_d;
  logic                pbit_q, pbit_d;
  logic                ferr_acc_q, ferr_acc_d;
  logic                stopz_q, stopz_d;
  logic [DBIT_MAX-1:0] dout_q, dout_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                brk_q, brk_d;
  logic                done_q, done_d;
  logic                data_par;

  assign data_par = ^shreg_q;

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    nbits_d    = nbits_q;
    par_d      = par_q;
    two_stop_d = two_stop_q;
    shreg_d    = shreg_q;
    pbit_d     = pbit_q;
    ferr_acc_d = ferr_acc_q;
    stopz_d    = stopz_q;
    dout_d     = dout_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // Frame format is captured once per frame; later input changes are ignored.
        if (fall) begin
          state_d    = START;
          s_d        = '0;
          nbits_d    = nbits_decode(data_bits, DBIT_MAX);
          par_d      = parity_decode(parity_mode);
          two_stop_d = stop_bits;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (bit_val) begin
              state_d = IDLE;
            end else begin
              state_d    = DATA;
              s_d        = '0;
              n_d        = '0;
              shreg_d    = '0;
              pbit_d     = 1'b0;
              ferr_acc_d = 1'b0;
              stopz_d    = 1'b1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_END) begin
            s_d = '0;
            for (int i = 0; i < DBIT_MAX; i++) begin
              if (n_q == 4'(i)) shreg_d[i] = bit_val;
            end
            if (n_q == nbits_q - 4'd1) begin
              n_d     = '0;
              state_d = (par_q == PAR_NONE) ? STOP : PARITY;
            end else begin
              n_d = n_q + 4'd1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_END) begin
            s_d     = '0;
            pbit_d  = bit_val;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_END) begin
            s_d = '0;
            if (n_q == {3'b000, two_stop_q}) begin
              // Last stop bit: fold it into the flags directly rather than via the accumulators.
              state_d = IDLE;
              n_d     = '0;
              done_d  = 1'b1;
              dout_d  = shreg_q;
              ferr_d  = ferr_acc_q | ~bit_val;
              brk_d   = (shreg_q == '0) & ((par_q == PAR_NONE) | ~pbit_q) & stopz_q & ~bit_val;
              case (par_q)
                PAR_EVEN: perr_d = data_par ^ pbit_q;
                PAR_ODD:  perr_d = ~(data_par ^ pbit_q);
                default:  perr_d = 1'b0;
              endcase
            end else begin
              n_d        = n_q + 4'd1;
              ferr_acc_d = ferr_acc_q | ~bit_val;
              stopz_d    = stopz_q & ~bit_val;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      s_q        <= '0;
      n_q        <= '0;
      nbits_q    <= '0;
      par_q      <= PAR_NONE;
      two_stop_q <= 1'b0;
      shreg_q    <= '0;
      pbit_q     <= 1'b0;
      ferr_acc_q <= 1'b0;
      stopz_q    <= 1'b0;
      dout_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      nbits_q    <= nbits_d;
      par_q      <= par_d;
      two_stop_q <= two_stop_d;
      shreg_q    <= shreg_d;
      pbit_q     <= pbit_d;
      ferr_acc_q <= ferr_acc_d;
      stopz_q    <= stopz_d;
      dout_q     <= dout_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      done_q     <= done_d;
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign break_det    = brk_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames, expected results queued, checked on each done pulse.
module tb_uart_rx_cfg;

  localparam int OVS      = 16;
  localparam int DBIT_MAX = 8;
  localparam int TICK_DIV = 4;

  logic                clk, reset, rx, s_tick, stop_bits;
  logic [1:0]          data_bits, parity_mode;
  logic                rx_done_tick, parity_err, frame_err, break_det;
  logic [DBIT_MAX-1:0] dout;
  logic [2:0]          dbg_state;

  uart_rx_cfg #(.DBIT_MAX(DBIT_MAX), .OVS(OVS), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .data_bits    (data_bits),
    .parity_mode  (parity_mode),
    .stop_bits    (stop_bits),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .break_det    (break_det),
    .dbg_state    (dbg_state)
  );

  // clock / reset / tick generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tick_cnt;
  initial begin
    tick_cnt = 0;
    s_tick   = 1'b0;
    forever begin
      @(negedge clk);
      s_tick   = (tick_cnt == TICK_DIV - 1);
      tick_cnt = (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before 3ms");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: {break_det, frame_err, parity_err, dout}
  int          tests_run = 0;
  int          fails     = 0;
  logic [10:0] exp_q[$];
  logic [10:0] e;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    tests_run++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic perr,
                                     input logic ferr, input logic brk);
    return {brk, ferr, perr, d};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rx_done_tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL unexpected_done: got frame dout=%0h, expected no frame", dout);
        end else begin
          e = exp_q.pop_front();
          check("dout", dout, e[7:0]);
          check("parity_err", 8'(parity_err), 8'(e[8]));
          check("frame_err", 8'(frame_err), 8'(e[9]));
          check("break_det", 8'(break_det), 8'(e[10]));
        end
        @(negedge clk);
        check("done_width", 8'(rx_done_tick), 8'd0);
      end
    end
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  // A glitched bit is inverted for exactly the tick at which the receiver samples it.
  task automatic drive_bit(input logic v, input logic glitch);
    rx = v;
    if (glitch) begin
      wait_ticks(7);
      rx = ~v;
      wait_ticks(1);
      rx = v;
      wait_ticks(OVS - 8);
    end else begin
      wait_ticks(OVS);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int nb, input logic has_par,
                            input logic pbit, input int nstop, input logic [1:0] stops,
                            input int glitch_bit);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(data[i], i == glitch_bit);
    if (has_par) drive_bit(pbit, 1'b0);
    for (int i = 0; i < nstop; i++) drive_bit(stops[i], 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic [1:0] pm, input logic sb);
    data_bits   = db;
    parity_mode = pm;
    stop_bits   = sb;
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    set_cfg(2'b11, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_dout", dout, 8'h00);
    check("reset_done", 8'(rx_done_tick), 8'd0);
    check("reset_perr", 8'(parity_err), 8'd0);
    check("reset_ferr", 8'(frame_err), 8'd0);
    check("reset_brk", 8'(break_det), 8'd0);
    check("reset_state", 8'(dbg_state), 8'd0);
    reset = 1'b0;
    wait_ticks(2);

    // 8N1 0xA5
    exp_q.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0));
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 2'b11, -1);

    // 7E1 0x35: four ones, so parity bit 0 is correct and 1 is an error
    set_cfg(2'b10, 2'b01, 1'b0);
    exp_q.push_back(mk(8'h35, 1'b0, 1'b0, 1'b0));
    send_frame(8'h35, 7, 1'b1, 1'b0, 1, 2'b11, -1);
    exp_q.push_back(mk(8'h35, 1'b1, 1'b0, 1'b0));
    send_frame(8'h35, 7, 1'b1, 1'b1, 1, 2'b11, -1);

    // 5O2 0x1F, correct odd parity 0, second stop bit low
    set_cfg(2'b00, 2'b10, 1'b1);
    exp_q.push_back(mk(8'h1F, 1'b0, 1'b1, 1'b0));
    send_frame(8'h1F, 5, 1'b1, 1'b0, 2, 2'b01, -1);

    // break: line low for 12 bit times
    set_cfg(2'b11, 2'b00, 1'b0);
    exp_q.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1));
    rx = 1'b0;
    wait_ticks(12 * OVS);
    check("break_frames_pending", 8'(exp_q.size()), 8'd0);
    rx = 1'b1;
    wait_ticks(2 * OVS);

    // false start: short low pulse leaves the break results in place
    rx = 1'b0;
    wait_ticks(OVS / 4);
    rx = 1'b1;
    wait_ticks(2 * OVS);
    check("false_start_dout", dout, 8'h00);
    check("false_start_ferr", 8'(frame_err), 8'd1);
    check("false_start_brk", 8'(break_det), 8'd1);
    check("false_start_state", 8'(dbg_state), 8'd0);
    exp_q.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0));
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 2'b11, -1);

    // reset in the middle of the data bits
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    rx    = 1'b1;
    reset = 1'b1;
    #1;
    check("midreset_dout", dout, 8'h00);
    check("midreset_state", 8'(dbg_state), 8'd0);
    check("midreset_ferr", 8'(frame_err), 8'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_ticks(2 * OVS);
    exp_q.push_back(mk(8'h81, 1'b0, 1'b0, 1'b0));
    send_frame(8'h81, 8, 1'b0, 1'b0, 1, 2'b11, -1);

    // 6E2 0x2A (three ones, parity bit 1); format inputs change mid-frame and must be ignored
    set_cfg(2'b01, 2'b01, 1'b1);
    exp_q.push_back(mk(8'h2A, 1'b0, 1'b0, 1'b0));
    fork
      send_frame(8'h2A, 6, 1'b1, 1'b1, 2, 2'b11, -1);
      begin
        wait_ticks(2 * OVS);
        set_cfg(2'b00, 2'b00, 1'b0);
      end
    join

`ifdef UART_RX_MAJORITY_EN
    // one-tick glitch exactly at the sample point of data bit 2
    set_cfg(2'b11, 2'b00, 1'b0);
    exp_q.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0));
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 2'b11, 2);
`endif

    wait_ticks(OVS);
    check("frames_pending", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
